rot_seq: RTL and testbench

Job sequencer for the image rotation accelerator. Detects the start request from the APB register block and latches the job configuration. Walks the source image in raster order and issues one source/destination byte-address pair per pixel to the DMA engine over a valid/ready command channel. Reports the rotated dimensions back to the register block and raises a done/error flag when the job has drained.

---
 rtl/rot_pkg.sv | 32 +++
 rtl/rot_addr_gen.sv | 110 +++++++++++
 rtl/rot_seq.sv | 182 ++++++++++++++++++
 tb/tb_rot_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types, encodings and default widths for the rotation job sequencer.
package rot_pkg;

    localparam int unsigned ROT_ADDR_W = 32;
    localparam int unsigned ROT_DIM_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } rot_state_e;

    typedef enum logic [1:0] {
        MODE_0    = 2'b00,
        MODE_90   = 2'b01,
        MODE_180  = 2'b10,
        MODE_RSVD = 2'b11
    } rot_mode_e;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } rot_dir_e;

    // Clockwise quarter turns: counter-clockwise rotation by m is clockwise by (4 - m) mod 4.
    function automatic logic [1:0] eff_angle(input logic [1:0] mode, input logic dir);
        return (dir == DIR_CCW) ? 2'(2'd0 - mode) : mode;
    endfunction

endpackage

// File: rtl/rot_addr_gen.sv
// Raster walker: source/destination pointers, per-angle steps and row/column counters.
module rot_addr_gen
    import rot_pkg::*;
#(
    parameter int unsigned ADDR_W = ROT_ADDR_W,
    parameter int unsigned DIM_W  = ROT_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] src_img,
    input  logic [ADDR_W-1:0] dst_img,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [1:0]        angle,
    output logic [ADDR_W-1:0] cmd_src,
    output logic [ADDR_W-1:0] cmd_dst,
    output logic              cmd_last
);

    localparam int unsigned P_W = 2 * DIM_W;

    logic [P_W-1:0]    prod;
    logic [ADDR_W-1:0] p_a;
    logic [ADDR_W-1:0] h_a;
    logic [ADDR_W-1:0] w_a;
    logic [ADDR_W-1:0] base_init;
    logic [ADDR_W-1:0] col_step_init;
    logic [ADDR_W-1:0] row_step_init;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] col_step_q;
    logic [ADDR_W-1:0] row_step_q;
    logic [ADDR_W-1:0] row_base_nxt;
    logic [DIM_W-1:0]  row_q;
    logic [DIM_W-1:0]  col_q;
    logic [DIM_W-1:0]  h_m1;
    logic [DIM_W-1:0]  w_m1;
    logic              col_end;

    assign prod         = P_W'(img_h) * P_W'(img_w);
    assign p_a          = ADDR_W'(prod);
    assign h_a          = ADDR_W'(img_h);
    assign w_a          = ADDR_W'(img_w);
    assign h_m1         = img_h - DIM_W'(1);
    assign w_m1         = img_w - DIM_W'(1);
    assign col_end      = (col_q == w_m1);
    assign row_base_nxt = row_base_q + row_step_q;

    // Destination origin and strides for each clockwise angle; negatives wrap modulo 2^ADDR_W.
    always_comb begin
        base_init     = dst_img;
        col_step_init = ADDR_W'(1);
        row_step_init = w_a;
        case (angle)
            2'd1: begin
                base_init     = dst_img + h_a - ADDR_W'(1);
                col_step_init = h_a;
                row_step_init = '1;
            end
            2'd2: begin
                base_init     = dst_img + p_a - ADDR_W'(1);
                col_step_init = '1;
                row_step_init = ADDR_W'(0) - w_a;
            end
            2'd3: begin
                base_init     = dst_img + p_a - h_a;
                col_step_init = ADDR_W'(0) - h_a;
                row_step_init = ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_src    <= '0;
            cmd_dst    <= '0;
            cmd_last   <= 1'b0;
            row_base_q <= '0;
            col_step_q <= '0;
            row_step_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else if (load) begin
            cmd_src    <= src_img;
            cmd_dst    <= base_init;
            cmd_last   <= (img_h == DIM_W'(1)) && (img_w == DIM_W'(1));
            row_base_q <= base_init;
            col_step_q <= col_step_init;
            row_step_q <= row_step_init;
            row_q      <= '0;
            col_q      <= '0;
        end else if (advance) begin
            cmd_src <= cmd_src + ADDR_W'(1);
            if (!col_end) begin
                col_q    <= col_q + DIM_W'(1);
                cmd_dst  <= cmd_dst + col_step_q;
                cmd_last <= (row_q == h_m1) && ((col_q + DIM_W'(1)) == w_m1);
            end else begin
                col_q      <= '0;
                row_q      <= row_q + DIM_W'(1);
                row_base_q <= row_base_nxt;
                cmd_dst    <= row_base_nxt;
                cmd_last   <= ((row_q + DIM_W'(1)) == h_m1) && (w_m1 == '0);
            end
        end
    end

endmodule

// File: rtl/rot_seq.sv
// Rotation job sequencer: start detection, config latch, job FSM and done/error flags.
module rot_seq
    import rot_pkg::*;
#(
    parameter int unsigned ADDR_W = ROT_ADDR_W,
    parameter int unsigned DIM_W  = ROT_DIM_W
) (
    input  logic              I_ROTSEQ_PCLK,
    input  logic              I_ROTSEQ_PRESET_N,
    input  logic              I_ROTSEQ_SOFT_RESET,
    input  logic              I_ROTSEQ_START,
    input  logic              I_ROTSEQ_INTR_CLEAR,
    input  logic [ADDR_W-1:0] I_ROTSEQ_SRC_IMG,
    input  logic [ADDR_W-1:0] I_ROTSEQ_DST_IMG,
    input  logic [DIM_W-1:0]  I_ROTSEQ_IMG_H,
    input  logic [DIM_W-1:0]  I_ROTSEQ_IMG_W,
    input  logic [1:0]        I_ROTSEQ_IMG_MODE,
    input  logic              I_ROTSEQ_IMG_DIR,
    input  logic              I_ROTSEQ_CMD_READY,
    input  logic              I_ROTSEQ_DMA_IDLE,
    output logic              O_ROTSEQ_CMD_VALID,
    output logic [ADDR_W-1:0] O_ROTSEQ_CMD_SRC,
    output logic [ADDR_W-1:0] O_ROTSEQ_CMD_DST,
    output logic              O_ROTSEQ_CMD_LAST,
    output logic [DIM_W-1:0]  O_ROTSEQ_NEW_H,
    output logic [DIM_W-1:0]  O_ROTSEQ_NEW_W,
    output logic              O_ROTSEQ_BUSY,
    output logic              O_ROTSEQ_DONE,
    output logic              O_ROTSEQ_ERR
);

    rot_state_e        state_q;
    rot_state_e        state_d;
    logic              job_rst_n;
    logic              start_q;
    logic              start_ok;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DIM_W-1:0]  h_q;
    logic [DIM_W-1:0]  w_q;
    logic [1:0]        mode_q;
    logic              dir_q;
    logic [1:0]        angle;
    logic              cfg_bad;
    logic              cmd_accept;
    logic              cmd_last;
    logic              load_c;
    logic              valid_q;
    logic              valid_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic              err_d;
    logic [DIM_W-1:0]  new_h_q;
    logic [DIM_W-1:0]  new_h_d;
    logic [DIM_W-1:0]  new_w_q;
    logic [DIM_W-1:0]  new_w_d;

    // Soft reset aborts the job exactly like the hard reset.
    assign job_rst_n  = I_ROTSEQ_PRESET_N & ~I_ROTSEQ_SOFT_RESET;
    assign start_ok   = I_ROTSEQ_START && !start_q &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign angle      = eff_angle(mode_q, dir_q);
    assign cfg_bad    = (mode_q == MODE_RSVD) || (h_q == '0) || (w_q == '0);
    assign cmd_accept = valid_q && I_ROTSEQ_CMD_READY;

    always_ff @(posedge I_ROTSEQ_PCLK) begin
        if (!job_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_SETUP;
            ST_SETUP: state_d = cfg_bad ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (cmd_accept && cmd_last) state_d = ST_DRAIN;
            ST_DRAIN: if (I_ROTSEQ_DMA_IDLE) state_d = ST_DONE;
            ST_DONE:  if (start_ok) state_d = ST_SETUP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; flag set beats clear.
    always_comb begin
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_SETUP) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d  = done_q;
        err_d   = err_q;
        new_h_d = new_h_q;
        new_w_d = new_w_q;
        load_c  = 1'b0;
        if (I_ROTSEQ_INTR_CLEAR || start_ok) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        case (state_q)
            ST_SETUP: begin
                if (cfg_bad) begin
                    err_d = 1'b1;
                end else begin
                    load_c  = 1'b1;
                    new_h_d = angle[0] ? w_q : h_q;
                    new_w_d = angle[0] ? h_q : w_q;
                end
            end
            ST_DRAIN: if (I_ROTSEQ_DMA_IDLE) done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge I_ROTSEQ_PCLK) begin
        if (!job_rst_n) begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            new_h_q <= '0;
            new_w_q <= '0;
        end else begin
            start_q <= I_ROTSEQ_START;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            new_h_q <= new_h_d;
            new_w_q <= new_w_d;
        end
    end

    // Job configuration is captured only on an accepted start edge.
    always_ff @(posedge I_ROTSEQ_PCLK) begin
        if (!job_rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            h_q    <= '0;
            w_q    <= '0;
            mode_q <= '0;
            dir_q  <= 1'b0;
        end else if (start_ok) begin
            src_q  <= I_ROTSEQ_SRC_IMG;
            dst_q  <= I_ROTSEQ_DST_IMG;
            h_q    <= I_ROTSEQ_IMG_H;
            w_q    <= I_ROTSEQ_IMG_W;
            mode_q <= I_ROTSEQ_IMG_MODE;
            dir_q  <= I_ROTSEQ_IMG_DIR;
        end
    end

    rot_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk      (I_ROTSEQ_PCLK),
        .rst_n    (job_rst_n),
        .load     (load_c),
        .advance  (cmd_accept),
        .src_img  (src_q),
        .dst_img  (dst_q),
        .img_h    (h_q),
        .img_w    (w_q),
        .angle    (angle),
        .cmd_src  (O_ROTSEQ_CMD_SRC),
        .cmd_dst  (O_ROTSEQ_CMD_DST),
        .cmd_last (cmd_last)
    );

    assign O_ROTSEQ_CMD_VALID = valid_q;
    assign O_ROTSEQ_CMD_LAST  = cmd_last;
    assign O_ROTSEQ_NEW_H     = new_h_q;
    assign O_ROTSEQ_NEW_W     = new_w_q;
    assign O_ROTSEQ_BUSY      = busy_q;
    assign O_ROTSEQ_DONE      = done_q;
    assign O_ROTSEQ_ERR       = err_q;

endmodule

// File: tb/tb_rot_seq.sv
// Self-checking bench for rot_seq: coordinate-mapping reference model plus directed and random jobs.
module tb_rot_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_reset = 1'b0;
    logic        start = 1'b0;
    logic        intr_clear = 1'b0;
    logic [31:0] src_img = '0;
    logic [31:0] dst_img = '0;
    logic [15:0] img_h = '0;
    logic [15:0] img_w = '0;
    logic [1:0]  img_mode = '0;
    logic        img_dir = 1'b0;
    logic        ready = 1'b1;
    logic        dma_idle = 1'b0;
    logic        valid;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic        cmd_last;
    logic [15:0] new_h;
    logic [15:0] new_w;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic        last;
    } cmd_t;

    cmd_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          nbeats = 0;
    bit          stall_en = 1'b0;
    logic [31:0] obs_dst[64];
    logic [31:0] obs_src[64];
    logic [15:0] last_nh = '0;
    logic [15:0] last_nw = '0;

    localparam logic [31:0] EXP_90CW  [6] = '{32'h2001, 32'h2003, 32'h2005, 32'h2000, 32'h2002, 32'h2004};
    localparam logic [31:0] EXP_180   [6] = '{32'h2005, 32'h2004, 32'h2003, 32'h2002, 32'h2001, 32'h2000};
    localparam logic [31:0] EXP_90CCW [6] = '{32'h2004, 32'h2002, 32'h2000, 32'h2005, 32'h2003, 32'h2001};

    rot_seq dut (
        .I_ROTSEQ_PCLK       (clk),
        .I_ROTSEQ_PRESET_N   (rst_n),
        .I_ROTSEQ_SOFT_RESET (soft_reset),
        .I_ROTSEQ_START      (start),
        .I_ROTSEQ_INTR_CLEAR (intr_clear),
        .I_ROTSEQ_SRC_IMG    (src_img),
        .I_ROTSEQ_DST_IMG    (dst_img),
        .I_ROTSEQ_IMG_H      (img_h),
        .I_ROTSEQ_IMG_W      (img_w),
        .I_ROTSEQ_IMG_MODE   (img_mode),
        .I_ROTSEQ_IMG_DIR    (img_dir),
        .I_ROTSEQ_CMD_READY  (ready),
        .I_ROTSEQ_DMA_IDLE   (dma_idle),
        .O_ROTSEQ_CMD_VALID  (valid),
        .O_ROTSEQ_CMD_SRC    (cmd_src),
        .O_ROTSEQ_CMD_DST    (cmd_dst),
        .O_ROTSEQ_CMD_LAST   (cmd_last),
        .O_ROTSEQ_NEW_H      (new_h),
        .O_ROTSEQ_NEW_W      (new_w),
        .O_ROTSEQ_BUSY       (busy),
        .O_ROTSEQ_DONE       (done),
        .O_ROTSEQ_ERR        (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int angle_of(input int mode, input int dir);
        return dir != 0 ? (4 - mode) % 4 : mode;
    endfunction

    // Reference: pixel (r,c) lands at its rotated coordinate in the rotated raster.
    task automatic push_job(input logic [31:0] src, input logic [31:0] dst,
                            input int h, input int w, input int mode, input int dir);
        int   a;
        int   nw;
        int   rr;
        int   cc;
        cmd_t e;
        a  = angle_of(mode, dir);
        nw = (a % 2 != 0) ? h : w;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (a)
                    0:       begin rr = r;         cc = c;         end
                    1:       begin rr = c;         cc = h - 1 - r; end
                    2:       begin rr = h - 1 - r; cc = w - 1 - c; end
                    default: begin rr = w - 1 - c; cc = r;         end
                endcase
                e.src  = src + 32'(r * w + c);
                e.dst  = dst + 32'(rr * nw + cc);
                e.last = (r == h - 1) && (c == w - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Compare process: every accepted beat against the model, every stall for payload stability.
    initial begin
        cmd_t        e;
        logic        prev_stall;
        logic [31:0] prev_src;
        logic [31:0] prev_dst;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_src   = '0;
        prev_dst   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && !soft_reset) begin
                if (prev_stall) begin
                    chk1("stall_valid_held", valid, 1'b1);
                    chk("stall_src_stable", cmd_src, prev_src);
                    chk("stall_dst_stable", cmd_dst, prev_dst);
                    chk1("stall_last_stable", cmd_last, prev_last);
                end
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(nbeats), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_src", cmd_src, e.src);
                        chk("beat_dst", cmd_dst, e.dst);
                        chk1("beat_last", cmd_last, e.last);
                    end
                    if (nbeats < 64) begin
                        obs_dst[nbeats] = cmd_dst;
                        obs_src[nbeats] = cmd_src;
                    end
                    nbeats++;
                end
                prev_stall = valid && !ready;
                prev_src   = cmd_src;
                prev_dst   = cmd_dst;
                prev_last  = cmd_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk1({tag, "_valid"}, valid, 1'b0);
        chk1({tag, "_last"}, cmd_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk({tag, "_src"}, cmd_src, 32'h0);
        chk({tag, "_dst"}, cmd_dst, 32'h0);
        chk({tag, "_new_h"}, 32'(new_h), 32'h0);
        chk({tag, "_new_w"}, 32'(new_w), 32'h0);
    endtask

    // smode: 0 = one-cycle start pulse, 1 = start held high, 2 = start and config toggled mid-job.
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int h, input int w,
                           input int mode, input int dir, input bit stall, input int smode,
                           input bit clr_at_done);
        int          a;
        int          cyc;
        logic [15:0] enh;
        logic [15:0] enw;
        a   = angle_of(mode, dir);
        enh = (a % 2 != 0) ? 16'(w) : 16'(h);
        enw = (a % 2 != 0) ? 16'(h) : 16'(w);
        push_job(src, dst, h, w, mode, dir);
        nbeats   = 0;
        stall_en = stall;
        @(posedge clk); #1;
        src_img  = src;
        dst_img  = dst;
        img_h    = 16'(h);
        img_w    = 16'(w);
        img_mode = 2'(mode);
        img_dir  = 1'(dir);
        start    = 1'b1;
        @(negedge clk);
        chk1("busy_before_start", busy, 1'b0);
        @(posedge clk); #1;
        if (smode == 0) start = 1'b0;
        @(negedge clk);
        chk1("busy_setup", busy, 1'b1);
        chk1("valid_setup", valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("valid_first", valid, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (smode == 2) begin
                start    = 1'($urandom_range(0, 1));
                src_img  = $urandom;
                dst_img  = $urandom;
                img_h    = 16'($urandom_range(0, 9));
                img_mode = 2'($urandom_range(0, 3));
            end
        end
        start    = 1'b0;
        stall_en = 1'b0;
        if (exp_q.size() != 0) begin
            chk("job_timeout_left", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        chk("beat_count", 32'(nbeats), 32'(h * w));
        @(negedge clk);
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_valid", valid, 1'b0);
        chk1("drain_done", done, 1'b0);
        @(posedge clk); #1;
        dma_idle   = 1'b1;
        intr_clear = clr_at_done;
        @(negedge clk);
        chk1("done_before_idle_sampled", done, 1'b0);
        @(posedge clk); #1;
        dma_idle   = 1'b0;
        intr_clear = 1'b0;
        @(negedge clk);
        chk1("done_set", done, 1'b1);
        chk1("done_busy", busy, 1'b0);
        chk1("done_err", err, 1'b0);
        chk("new_h", 32'(new_h), 32'(enh));
        chk("new_w", 32'(new_w), 32'(enw));
        last_nh = enh;
        last_nw = enw;
        @(posedge clk); #1;
        intr_clear = 1'b1;
        @(posedge clk); #1;
        intr_clear = 1'b0;
        @(negedge clk);
        chk1("done_cleared", done, 1'b0);
    endtask

    task automatic run_err(input int h, input int w, input int mode);
        @(posedge clk); #1;
        img_h    = 16'(h);
        img_w    = 16'(w);
        img_mode = 2'(mode);
        img_dir  = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk1("err_setup_busy", busy, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("err_set", err, 1'b1);
        chk1("err_done", done, 1'b0);
        chk1("err_busy", busy, 1'b0);
        chk1("err_valid", valid, 1'b0);
        chk("err_new_h_kept", 32'(new_h), 32'(last_nh));
        chk("err_new_w_kept", 32'(new_w), 32'(last_nw));
        repeat (2) @(posedge clk);
        #1;
        intr_clear = 1'b1;
        @(posedge clk); #1;
        intr_clear = 1'b0;
        @(negedge clk);
        chk1("err_cleared", err, 1'b0);
    endtask

    initial begin
        int          cyc;
        int          h;
        int          w;
        int          m;
        int          d;
        logic [31:0] s;
        logic [31:0] dd;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        run_job(32'h1000, 32'h2000, 2, 3, 1, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("dst_90cw", obs_dst[i], EXP_90CW[i]);
            chk("src_90cw", obs_src[i], 32'h1000 + 32'(i));
        end
        chk("new_h_90cw_lit", 32'(new_h), 32'd3);
        chk("new_w_90cw_lit", 32'(new_w), 32'd2);

        run_job(32'h1000, 32'h2000, 2, 3, 2, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) chk("dst_180", obs_dst[i], EXP_180[i]);
        chk("new_h_180_lit", 32'(new_h), 32'd2);

        run_job(32'h1000, 32'h2000, 2, 3, 1, 1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) chk("dst_90ccw", obs_dst[i], EXP_90CCW[i]);

        run_err(2, 3, 3);

        run_job(32'h1000, 32'h2000, 2, 3, 1, 0, 1'b1, 1, 1'b0);
        run_job(32'h1000, 32'h2000, 2, 3, 2, 1, 1'b1, 2, 1'b0);

        run_job(32'h1000, 32'hFFFF_FFFE, 2, 3, 0, 0, 1'b0, 0, 1'b0);
        chk("wrap_dst1", obs_dst[1], 32'hFFFF_FFFF);
        chk("wrap_dst2", obs_dst[2], 32'h0000_0000);

        run_err(0, 3, 0);
        run_err(2, 0, 1);

        run_job(32'h1000, 32'h2000, 2, 3, 1, 0, 1'b0, 0, 1'b1);

        // Abort a job after three accepted beats.
        push_job(32'h1000, 32'h2000, 2, 3, 1, 0);
        nbeats = 0;
        @(posedge clk); #1;
        src_img  = 32'h1000;
        dst_img  = 32'h2000;
        img_h    = 16'd2;
        img_w    = 16'd3;
        img_mode = 2'd1;
        img_dir  = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (nbeats < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (nbeats < 3) chk("soft_wait_beats", 32'(nbeats), 32'd3);
        @(posedge clk); #1;
        soft_reset = 1'b1;
        @(posedge clk); #1;
        soft_reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("soft");
        last_nh = '0;
        last_nw = '0;
        repeat (2) @(negedge clk);
        chk1("soft_idle_valid", valid, 1'b0);
        run_job(32'h1000, 32'h2000, 2, 3, 1, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            h  = $urandom_range(1, 5);
            w  = $urandom_range(1, 5);
            m  = $urandom_range(0, 2);
            d  = $urandom_range(0, 1);
            s  = $urandom;
            dd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            if (i % 6 == 5) begin
                case ($urandom_range(0, 2))
                    0:       run_err(0, w, m);
                    1:       run_err(h, 0, m);
                    default: run_err(h, w, 3);
                endcase
            end else begin
                run_job(s, dd, h, w, m, d, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                        1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
